hazard_sequencer: RTL and testbench
===================================

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 SHALL have parameter MD_MAX_CYCLES, default 34: watchdog limit, in cycles, for a multi-cycle mul/div op.
REQ-002 SHALL have parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports Rs1D, Rs2D  in  5 each  source registers of the instruction in Decode.
REQ-006 SHALL have port RdE  in  5  destination register of the instruction in Execute.
REQ-007 SHALL have port LoadE  in  1  instruction in Execute is a load.
REQ-008 SHALL have port PCSrcE  in  1  branch/jump taken in Execute.
REQ-009 SHALL have port MdReqE  in  1  instruction in Execute is a multi-cycle mul/div.
REQ-010 SHALL have port MdDone  in  1  mul/div unit result valid (single-cycle pulse).
REQ-011 SHALL have ports StallF, StallD, StallE  out  1 each  hold the Fetch, Decode and Execute pipeline registers.
REQ-012 SHALL have ports FlushD, FlushE  out  1 each  clear the Decode and Execute pipeline registers.
REQ-013 SHALL have port MdStart  out  1  one-cycle start pulse to the mul/div unit.
REQ-014 SHALL have port MdTimeout  out  1  sticky watchdog-expired flag.
REQ-015 SHALL have port StallCount  out  CNT_W  saturating count of cycles with StallF=1.

Function
REQ-016 SHALL implement FSM states RUN and MD_WAIT; all outputs are combinational from the state and inputs, except StallCount and MdTimeout, which are registered.
REQ-017 SHALL define lwStall = LoadE & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D).
REQ-018 In RUN with MdReqE=0: StallF=StallD=lwStall, StallE=0, FlushD=PCSrcE, FlushE=lwStall|PCSrcE, MdStart=0.
REQ-019 In RUN with MdReqE=1: StallF=StallD=StallE=1, MdStart=1, FlushD=FlushE=0, lwStall and PCSrcE ignored; next state MD_WAIT, watchdog counter loads 1.
REQ-020 In MD_WAIT with MdDone=0 and watchdog count < MD_MAX_CYCLES: StallF=StallD=StallE=1, flushes 0, MdStart 0, watchdog count +1.
REQ-021 In MD_WAIT with MdDone=1: all stalls 0 in that same cycle (Execute advances at that edge), flushes 0; next state RUN.
REQ-022 In MD_WAIT with MdDone=0 and watchdog count == MD_MAX_CYCLES: all stalls 0, MdTimeout set to 1 at that edge; next state RUN.
REQ-023 MdTimeout SHALL stay 1 until reset.
REQ-024 MdDone SHALL be ignored in RUN; MdReqE, lwStall and PCSrcE SHALL be ignored in MD_WAIT.
REQ-025 MdStart SHALL never be high on two consecutive cycles.
REQ-026 StallCount SHALL increment on each edge where StallF=1 and hold at 2^CNT_W-1 (no wrap).
REQ-027 A register index of 0 SHALL never produce a load-use stall.

Reset
REQ-028 While rst_n=0, asynchronously: state=RUN, watchdog count=0, MdTimeout=0, StallCount=0.
REQ-029 Reset asserted in MD_WAIT SHALL abort the op: after release, state is RUN and MdStart is 0 until a new MdReqE.
REQ-030 Combinational outputs during reset SHALL follow RUN-state equations.

Verification
REQ-031 LoadE=1, RdE=5, Rs1D=5 -> StallF=StallD=1, FlushE=1, StallE=0; StallCount increments by 1.
REQ-032 LoadE=1, RdE=0, Rs1D=0 -> no stall, no flush.
REQ-033 PCSrcE=1 in RUN -> FlushD=FlushE=1, no stalls.
REQ-034 MdReqE=1, MdDone pulsed 4 cycles later -> MdStart high in cycle 0 only; StallF/D/E high cycles 0-3 and low in cycle 4; state RUN in cycle 5.
REQ-035 MdReqE=1, MD_MAX_CYCLES=4, no MdDone -> stalls released on the 4th MD_WAIT cycle; MdTimeout=1 thereafter.
REQ-036 rst_n pulsed low mid MD_WAIT -> immediate RUN; StallCount=0; MdTimeout=0.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: load-use stalls, branch flushes and a multi-cycle
// mul/div handshake with a watchdog, plus a saturating stall-cycle counter.
module hazard_sequencer #(
  parameter int MD_MAX_CYCLES = 34,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic             MdReqE,
  input  logic             MdDone,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             MdStart,
  output logic             MdTimeout,
  output logic [CNT_W-1:0] StallCount
);

  localparam int WD_W = $clog2(MD_MAX_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MD_MAX_CYCLES);
  localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);

  localparam logic RUN     = 1'b0;
  localparam logic MD_WAIT = 1'b1;

  logic             r_state;
  logic [WD_W-1:0]  r_wd_cnt;
  logic             r_timeout;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_lw_stall;
  logic             w_next_state;
  logic [WD_W-1:0]  w_wd_next;
  logic             w_timeout_set;

  // Register 0 is hardwired zero, so a load targeting it never creates a hazard.
  assign w_lw_stall = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    StallF        = 1'b0;
    StallD        = 1'b0;
    StallE        = 1'b0;
    FlushD        = 1'b0;
    FlushE        = 1'b0;
    MdStart       = 1'b0;
    w_next_state  = r_state;
    w_wd_next     = r_wd_cnt;
    w_timeout_set = 1'b0;

    case (r_state)
      RUN: begin
        if (MdReqE) begin
          StallF       = 1'b1;
          StallD       = 1'b1;
          StallE       = 1'b1;
          MdStart      = 1'b1;
          w_next_state = MD_WAIT;
          w_wd_next    = WD_ONE;
        end else begin
          StallF = w_lw_stall;
          StallD = w_lw_stall;
          FlushD = PCSrcE;
          FlushE = w_lw_stall | PCSrcE;
        end
      end
      MD_WAIT: begin
        // A completing result wins over an expiring watchdog in the same cycle.
        if (MdDone) begin
          w_next_state = RUN;
          w_wd_next    = '0;
        end else if (r_wd_cnt == WD_LIMIT) begin
          w_next_state  = RUN;
          w_wd_next     = '0;
          w_timeout_set = 1'b1;
        end else begin
          StallF    = 1'b1;
          StallD    = 1'b1;
          StallE    = 1'b1;
          w_wd_next = r_wd_cnt + WD_ONE;
        end
      end
      default: begin
        w_next_state = RUN;
        w_wd_next    = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_wd_cnt <= '0;
    end else begin
      r_state  <= w_next_state;
      r_wd_cnt <= w_wd_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (w_timeout_set) r_timeout <= 1'b1;
      if (StallF && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign MdTimeout  = r_timeout;
  assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: directed scenarios then random traffic,
// expected responses queued by the driver and compared by a negedge monitor.
module tb_hazard_sequencer;

  localparam int MDMAX   = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0]       Rs1D = '0, Rs2D = '0, RdE = '0;
  logic             LoadE = 1'b0, PCSrcE = 1'b0, MdReqE = 1'b0, MdDone = 1'b0;
  logic             StallF, StallD, StallE, FlushD, FlushE, MdStart, MdTimeout;
  logic [CNT_W-1:0] StallCount;

  hazard_sequencer #(.MD_MAX_CYCLES(MDMAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MdReqE(MdReqE), .MdDone(MdDone),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .MdStart(MdStart),
    .MdTimeout(MdTimeout), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  // comb = {StallF, StallD, StallE, FlushD, FlushE, MdStart}
  typedef struct {
    logic [5:0]       comb;
    logic             tmo;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: an outstanding mul/div op is remembered by the cycle it
  // was issued; its age is simply the number of cycles elapsed since then.
  bit m_busy  = 0;
  int m_start = 0;
  int m_cyc   = 0;
  bit m_tmo   = 0;
  int m_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rst, input bit ld, input bit pc, input bit req,
                       input bit done, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2);
    exp_t e;
    bit   lw, s;
    int   age;
    @(posedge clk);
    #1;
    rst_n  = rst;
    LoadE  = ld;
    PCSrcE = pc;
    MdReqE = req;
    MdDone = done;
    RdE    = rd;
    Rs1D   = rs1;
    Rs2D   = rs2;
    if (!rst) begin
      m_busy = 0;
      m_tmo  = 0;
      m_cnt  = 0;
    end
    lw  = ld && (rd != 0) && (rd == rs1 || rd == rs2);
    age = m_cyc - m_start;
    if (!m_busy) begin
      if (req) e.comb = 6'b111_00_1;
      else     e.comb = {lw, lw, 1'b0, pc, lw | pc, 1'b0};
    end else begin
      s      = !(done || age == MDMAX);
      e.comb = {s, s, s, 3'b000};
    end
    e.tmo = m_tmo;
    e.cnt = CNT_W'(m_cnt);
    q.push_back(e);
    if (rst) begin
      if (e.comb[5] && m_cnt < CNT_MAX) m_cnt++;
      if (!m_busy) begin
        if (req) begin
          m_busy  = 1;
          m_start = m_cyc;
        end
      end else if (done) begin
        m_busy = 0;
      end else if (age == MDMAX) begin
        m_busy = 0;
        m_tmo  = 1;
      end
      m_cyc++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  // Monitor: outputs are presented every cycle, sampled mid-period.
  initial begin : monitor
    exp_t e;
    logic prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("comb_outputs", {26'd0, StallF, StallD, StallE, FlushD, FlushE, MdStart},
              {26'd0, e.comb});
        check("md_timeout", {31'd0, MdTimeout}, {31'd0, e.tmo});
        check("stall_count", {{(32-CNT_W){1'b0}}, StallCount}, {{(32-CNT_W){1'b0}}, e.cnt});
      end
      check("md_start_single_pulse", {31'd0, prev_start & MdStart}, 32'd0);
      prev_start = MdStart;
    end
  end

  initial begin : stimulus
    // Reset state, with hazards present to show RUN equations hold in reset.
    drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    drive(0, 1, 1, 0, 0, 5'd3, 5'd3, 5'd0);
    idle(1);
    // Load-use on Rs1D, then on Rs2D, then counter observed after.
    drive(1, 1, 0, 0, 0, 5'd5, 5'd5, 5'd9);
    idle(1);
    drive(1, 1, 0, 0, 0, 5'd7, 5'd1, 5'd7);
    // Register 0 never stalls; non-matching load never stalls.
    drive(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    drive(1, 1, 0, 0, 0, 5'd4, 5'd2, 5'd3);
    // Branch taken, alone and combined with a load-use.
    drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    drive(1, 1, 1, 0, 0, 5'd6, 5'd6, 5'd6);
    // Mul/div with MdDone four cycles later; hazards/requests ignored while waiting.
    drive(1, 1, 1, 1, 1, 5'd5, 5'd5, 5'd0);
    drive(1, 1, 1, 1, 0, 5'd5, 5'd5, 5'd0);
    drive(1, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
    drive(1, 1, 0, 0, 0, 5'd8, 5'd0, 5'd8);
    drive(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    idle(2);
    drive(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    // Watchdog expiry with no MdDone.
    drive(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    idle(MDMAX + 3);
    // Reset in the middle of MD_WAIT aborts the op and clears the sticky flag.
    drive(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    idle(2);
    drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    idle(3);
    // Counter saturation.
    for (int i = 0; i < CNT_MAX + 4; i++) drive(1, 1, 0, 0, 0, 5'd12, 5'd12, 5'd1);
    drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    // Random traffic with small register indices so hazards are frequent.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(99) != 0), $urandom_range(1), ($urandom_range(3) == 0),
            ($urandom_range(7) == 0), ($urandom_range(5) == 0),
            5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)));
    end
    idle(2);
    repeat (3) @(posedge clk);
    check("scoreboard_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
